// File: rtl/vigna_bus_arbiter.sv
// Two-master to one-slave bus arbiter for the vigna core.
// The instruction and data ports share one registered bus. A port is granted
// only from IDLE, the owner is held until the slave answers with m_ready, and
// the ready back to the owner is a combinational pass-through of m_ready.
module vigna_bus_arbiter #(
    parameter int PRIORITY_MODE = 0  // 0: round-robin, 1: data port always wins
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,

    output logic        grant_d
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // 1 when the most recently completed transaction belonged to the data port
    logic        last_grant_d;
    logic        last_grant_d_nxt;

    logic        m_valid_nxt;
    logic [31:0] m_addr_nxt;
    logic [31:0] m_wdata_nxt;
    logic [3:0]  m_wstrb_nxt;
    logic        grant_d_nxt;

    // Which port would win if a grant were issued this cycle
    logic        pick_d;

    // Arbitration decision: a lone requester wins; contention is resolved by mode
    always_comb begin
        pick_d = 1'b0;
        if (d_valid && !i_valid) begin
            pick_d = 1'b1;
        end else if (d_valid && i_valid) begin
            if (PRIORITY_MODE == 1) begin
                pick_d = 1'b1;
            end else begin
                // Round-robin: hand the bus to whoever did not have it last
                pick_d = ~last_grant_d;
            end
        end
    end

    // Next-state and next-bus-value logic; everything holds unless told otherwise
    always_comb begin
        state_nxt        = state;
        last_grant_d_nxt = last_grant_d;
        m_valid_nxt      = m_valid;
        m_addr_nxt       = m_addr;
        m_wdata_nxt      = m_wdata;
        m_wstrb_nxt      = m_wstrb;
        grant_d_nxt      = grant_d;

        case (state)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_nxt   = BUSY;
                    m_valid_nxt = 1'b1;
                    grant_d_nxt = pick_d;
                    if (pick_d) begin
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                        m_wstrb_nxt = d_wstrb;
                    end else begin
                        // Instruction fetches are always reads
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = 32'h0;
                        m_wstrb_nxt = 4'h0;
                    end
                end
            end

            BUSY: begin
                // Address, data and owner stay frozen until the slave answers
                if (m_ready) begin
                    state_nxt        = IDLE;
                    m_valid_nxt      = 1'b0;
                    m_wstrb_nxt      = 4'h0;
                    last_grant_d_nxt = grant_d;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and round-robin history
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant_d <= last_grant_d_nxt;
        end
    end

    // Registered shared-bus request; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_addr  <= 32'h0;
            m_wdata <= 32'h0;
            m_wstrb <= 4'h0;
            grant_d <= 1'b0;
        end else begin
            m_valid <= m_valid_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            m_wstrb <= m_wstrb_nxt;
            grant_d <= grant_d_nxt;
        end
    end

    // Completion is steered only to the owner and only while a transaction is open;
    // a stray m_ready in IDLE never reaches either port
    assign i_ready = m_ready && (state == BUSY) && !grant_d;
    assign d_ready = m_ready && (state == BUSY) &&  grant_d;

    // Read data is broadcast; each requester qualifies it with its own ready
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule
